mu0_write_tracer: RTL and testbench
===================================

// Module: mu0_write_tracer
// PURPOSE
//  Bus monitor downstream of the MU0 core. Snoops the core's memory-write port (Wr/Addr/Dout) and Halted.
//  Each accepted write is timestamped with a cycle count and queued in a FIFO for a bench or debug host.
//  Raises done once MU0 has halted and every queued write has been read out.
//  Purely passive: never drives the MU0/memory bus.
// PARAMETERS
//  DEPTH   16  trace FIFO entries; power of two, >=2
//  ADDR_W  12  MU0 address width
//  DATA_W  16  MU0 data width
//  CYC_W   16  timestamp counter width
// PORTS
//  Clk       in   1           system clock, rising edge
//  Reset     in   1           asynchronous, active-low reset
//  Wr        in   1           MU0 write strobe, sampled at rising Clk
//  Addr      in   ADDR_W      MU0 address bus
//  Dout      in   DATA_W      MU0 write data
//  Halted    in   1           MU0 halted flag
//  rd_req    in   1           pop the head entry (consumer ready)
//  rd_valid  out  1           FIFO non-empty; head entry presented
//  rd_cycle  out  CYC_W       head entry timestamp
//  rd_addr   out  ADDR_W      head entry address
//  rd_data   out  DATA_W      head entry data
//  count     out  log2(DEPTH)+1  entries currently held
//  overflow  out  1           sticky: a write was dropped because the FIFO was full
//  done      out  1           MU0 halted and FIFO drained
// BEHAVIOUR
//  Reset low (async): FSM=RUN, cycle=0, FIFO empty. Outputs: rd_valid=0, rd_*=0, count=0, overflow=0, done=0.
//  FSM states:
//   RUN:    cycle += 1 each Clk, saturating at all-ones. Writes are captured.
//           Halted=1 sampled -> HALT.
//   HALT:   cycle frozen; Wr ignored. FIFO empty (after any pop this cycle) -> DONE.
//   DONE:   done=1. Holds until reset.
//   Halted=0 while in HALT or DONE does not change state.
//  Capture: in RUN, a Clk edge with Wr=1 pushes {cycle,Addr,Dout}. cycle is the pre-increment value.
//   The first cycle after reset release has cycle=0.
//  Capture is also permitted on the edge that samples Halted=1 (the halting instruction's final write is kept).
//  Read side is first-word fall-through: rd_* show the head whenever rd_valid=1.
//   rd_* = 0 when empty.
//  Pop: rd_req=1 && rd_valid=1 at a Clk edge removes the head. Next entry visible the following cycle.
//   rd_req while empty is ignored.
//  Push to empty FIFO: rd_valid rises on the cycle after the edge (1-cycle latency).
//  Full (count==DEPTH):
//   push without pop -> entry dropped, overflow set (sticky to reset), count unchanged.
//   push with simultaneous pop -> both accepted, no overflow.
//  Empty with simultaneous push and rd_req -> push accepted, no pop.
//  Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count = pushes - pops, never exceeds DEPTH.
//  Reset asserted mid-operation clears the FIFO and all flags immediately; pending entries are lost.
// TESTING
//  1 Reset low 2 cyc, release; Wr=1 Addr=0x010 Dout=0xBEEF on cyc 3
//     -> rd_valid next cyc, rd_cycle=3, rd_addr=0x010, rd_data=0xBEEF, count=1.
//  2 Push 16 writes (data 0..15), no reads; 17th Wr
//     -> count=16, overflow=1, then 16 pops return data 0..15 in order.
//  3 FIFO full, Wr=1 and rd_req=1 same edge
//     -> count stays 16, overflow stays 0, head advances by one.
//  4 Three writes queued, Halted=1 with Wr=1 same edge, then Wr pulses
//     -> 4 entries only; done=0 until 4th pop, done=1 cycle after.
//  5 rd_req=1 while empty, then single push
//     -> no underflow, count=1, rd_valid=1.
//  6 Reset low mid-run with 5 entries
//     -> rd_valid=0, count=0, overflow=0, done=0 immediately (async, no Clk edge).

Source files
------------

// File: rtl/mu0_write_tracer.sv
// MU0 write tracer: a passive monitor on the MU0 memory-write port.
// It timestamps each write, queues it in a FIFO for a debug host to read,
// and raises done once the core has halted and the queue has drained.
//
// state | meaning
// RUN   | core running; cycle counter advances, writes are captured
// HALT  | core halted; counter frozen, writes ignored, waiting for drain
// DONE  | halted and drained; done held high until reset
module mu0_write_tracer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int CYC_W  = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Wr,
    input  logic [ADDR_W-1:0]        Addr,
    input  logic [DATA_W-1:0]        Dout,
    input  logic                     Halted,
    input  logic                     rd_req,
    output logic                     rd_valid,
    output logic [CYC_W-1:0]         rd_cycle,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = CYC_W + ADDR_W + DATA_W;

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [CYC_W-1:0]   cycle;
    logic [ENT_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count_next;
    logic               full;
    logic               push, pop, push_ok;
    logic [ENT_W-1:0]   head;

    assign full     = (count == CNT_FULL);
    assign rd_valid = (count != '0);
    assign push     = (state == RUN) && Wr;
    assign pop      = rd_req && rd_valid;
    // a full FIFO still accepts a push when the head leaves on the same edge
    assign push_ok  = push && (!full || pop);
    assign head     = mem[rd_ptr];
    assign done     = (state == DONE);

    // state register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= RUN;
        else        state <= state_next;
    end

    // next-state: halt on sampled Halted, finish once the queue is empty after this edge
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (Halted) state_next = HALT;
            HALT:    if (count_next == '0) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = RUN;
        endcase
    end

    // occupancy after this edge
    always_comb begin
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    // timestamp counter: runs only in RUN, saturates at all-ones
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            cycle <= '0;
        else if (state == RUN && cycle != '1)
            cycle <= cycle + CYC_ONE;
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_next;
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until counted valid
    always_ff @(posedge Clk) begin
        if (push_ok) mem[wr_ptr] <= {cycle, Addr, Dout};
    end

    // first-word fall-through read port, zeroed when empty
    always_comb begin
        rd_cycle = '0;
        rd_addr  = '0;
        rd_data  = '0;
        if (rd_valid) begin
            rd_cycle = head[ENT_W-1 -: CYC_W];
            rd_addr  = head[DATA_W +: ADDR_W];
            rd_data  = head[DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_mu0_write_tracer.sv
// Self-checking bench for mu0_write_tracer against a queue-based reference model.
module tb_mu0_write_tracer;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int CYC_W  = 16;

    logic                Clk, Reset, Wr, Halted, rd_req;
    logic [ADDR_W-1:0]   Addr;
    logic [DATA_W-1:0]   Dout;
    logic                rd_valid, overflow, done;
    logic [CYC_W-1:0]    rd_cycle;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_data;
    logic [4:0]          count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [CYC_W-1:0]  cyc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t mq[$];
    int   m_cycle;
    int   m_phase;   // 0 running, 1 halted, 2 finished
    bit   m_ovf;

    mu0_write_tracer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CYC_W(CYC_W)) dut (
        .Clk(Clk), .Reset(Reset), .Wr(Wr), .Addr(Addr), .Dout(Dout), .Halted(Halted),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_cycle(rd_cycle), .rd_addr(rd_addr),
        .rd_data(rd_data), .count(count), .overflow(overflow), .done(done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic model_clear();
        mq.delete();
        m_cycle = 0;
        m_phase = 0;
        m_ovf   = 1'b0;
    endtask

    // advance the reference model by one edge using current inputs, then clock the DUT
    task automatic tick();
        ent_t e;
        bit   do_pop;
        do_pop = rd_req && (mq.size() > 0);
        if (do_pop) void'(mq.pop_front());
        if (m_phase == 0 && Wr) begin
            e.cyc  = CYC_W'(m_cycle);
            e.addr = Addr;
            e.data = Dout;
            if (mq.size() < DEPTH) mq.push_back(e);
            else m_ovf = 1'b1;
        end
        if (m_phase == 0) begin
            if (m_cycle < (1 << CYC_W) - 1) m_cycle++;
            if (Halted) m_phase = 1;
        end else if (m_phase == 1) begin
            if (mq.size() == 0) m_phase = 2;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset  = 1'b0;
        Wr     = 1'b0;
        Halted = 1'b0;
        rd_req = 1'b0;
        Addr   = '0;
        Dout   = '0;
        repeat (2) @(posedge Clk);
        #1;
        model_clear();
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        #3;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", rd_valid); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (overflow !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags got ovf=%0b done=%0b exp 0/0", overflow, done); end
        checks++; if (rd_cycle !== '0 || rd_addr !== '0 || rd_data !== '0) begin errors++; $display("FAIL reset_rd got cyc=%0h addr=%0h data=%0h exp 0", rd_cycle, rd_addr, rd_data); end
        do_reset();
    endtask

    task automatic test_first_write();
        do_reset();
        repeat (3) tick();
        Wr = 1'b1; Addr = 12'h010; Dout = 16'hBEEF;
        tick();
        Wr = 1'b0;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%0b exp=1", rd_valid); end
        checks++; if (rd_cycle !== 16'd3) begin errors++; $display("FAIL first_cycle got=%0d exp=3", rd_cycle); end
        checks++; if (rd_addr !== 12'h010 || rd_data !== 16'hBEEF) begin errors++; $display("FAIL first_entry got addr=%0h data=%0h exp 010/beef", rd_addr, rd_data); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL first_count got=%0d exp=1", count); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            Wr = 1'b1; Addr = 12'(i); Dout = 16'(i);
            tick();
        end
        Wr = 1'b0;
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got=%0d exp=16", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (rd_valid !== 1'b1 || rd_data !== 16'(i)) begin errors++; $display("FAIL ovf_pop%0d got valid=%0b data=%0d exp 1/%0d", i, rd_valid, rd_data, i); end
            rd_req = 1'b1;
            tick();
        end
        rd_req = 1'b0;
        checks++; if (rd_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL ovf_drained got valid=%0b count=%0d exp 0/0", rd_valid, count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            Wr = 1'b1; Addr = 12'(100 + i); Dout = 16'(16'h0A00 + i);
            tick();
        end
        Wr = 1'b1; Addr = 12'h3FF; Dout = 16'h5555; rd_req = 1'b1;
        tick();
        Wr = 1'b0; rd_req = 1'b0;
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL fullpp_count got=%0d exp=16", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_ovf got=%0b exp=0", overflow); end
        checks++; if (rd_data !== 16'h0A01 || rd_addr !== 12'd101) begin errors++; $display("FAIL fullpp_head got addr=%0d data=%0h exp 101/a01", rd_addr, rd_data); end
        rd_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (rd_data !== mq[0].data || rd_cycle !== mq[0].cyc) begin errors++; $display("FAIL fullpp_drain%0d got data=%0h cyc=%0d exp %0h/%0d", i, rd_data, rd_cycle, mq[0].data, mq[0].cyc); end
            tick();
        end
        rd_req = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL fullpp_empty got=%0b exp=0", rd_valid); end
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            Wr = 1'b1; Addr = 12'(i + 1); Dout = 16'(16'hC000 + i);
            tick();
        end
        Wr = 1'b1; Halted = 1'b1; Addr = 12'h0FF; Dout = 16'hC0DE;
        tick();
        for (int i = 0; i < 3; i++) begin
            Wr = 1'b1; Addr = 12'h777; Dout = 16'hDEAD;
            tick();
            Wr = 1'b0;
            tick();
        end
        Halted = 1'b0;
        checks++; if (count !== 5'd4) begin errors++; $display("FAIL halt_count got=%0d exp=4", count); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL halt_done_early%0d got=%0b exp=0", i, done); end
            checks++; if (rd_data !== mq[0].data || rd_cycle !== mq[0].cyc) begin errors++; $display("FAIL halt_entry%0d got data=%0h cyc=%0d exp %0h/%0d", i, rd_data, rd_cycle, mq[0].data, mq[0].cyc); end
            rd_req = 1'b1;
            tick();
            rd_req = 1'b0;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL halt_done got=%0b exp=1", done); end
        Wr = 1'b1;
        tick(); tick();
        Wr = 1'b0;
        checks++; if (done !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL halt_hold got done=%0b count=%0d exp 1/0", done, count); end
    endtask

    task automatic test_empty_read();
        do_reset();
        rd_req = 1'b1;
        tick(); tick();
        checks++; if (count !== 5'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL empty_rd got count=%0d valid=%0b exp 0/0", count, rd_valid); end
        Wr = 1'b1; Addr = 12'h123; Dout = 16'h4567;
        tick();
        Wr = 1'b0; rd_req = 1'b0;
        checks++; if (count !== 5'd1 || rd_valid !== 1'b1) begin errors++; $display("FAIL empty_push got count=%0d valid=%0b exp 1/1", count, rd_valid); end
        checks++; if (rd_data !== 16'h4567 || rd_cycle !== 16'd2) begin errors++; $display("FAIL empty_entry got data=%0h cyc=%0d exp 4567/2", rd_data, rd_cycle); end
    endtask

    task automatic test_random();
        ent_t exp;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            Wr     = ($urandom_range(0, 9) < 6);
            rd_req = ($urandom_range(0, 9) < 4);
            Addr   = ADDR_W'($urandom);
            Dout   = DATA_W'($urandom);
            Halted = (i > 300) && ($urandom_range(0, 19) == 0);
            if (i > 340) rd_req = 1'b1;
            tick();
            exp = '{default: '0};
            if (mq.size() > 0) exp = mq[0];
            checks++;
            if (rd_valid !== (mq.size() > 0) || count !== 5'(mq.size()) ||
                rd_cycle !== exp.cyc || rd_addr !== exp.addr || rd_data !== exp.data ||
                overflow !== m_ovf || done !== (m_phase == 2)) begin
                errors++;
                $display("FAIL rand%0d got v=%0b n=%0d c=%0d a=%0h d=%0h o=%0b dn=%0b exp v=%0b n=%0d c=%0d a=%0h d=%0h o=%0b dn=%0b",
                         i, rd_valid, count, rd_cycle, rd_addr, rd_data, overflow, done,
                         mq.size() > 0, mq.size(), exp.cyc, exp.addr, exp.data, m_ovf, m_phase == 2);
            end
        end
        Wr = 1'b0; rd_req = 1'b0; Halted = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            Wr = 1'b1; Addr = 12'(i); Dout = 16'(i + 50);
            tick();
        end
        Wr = 1'b0;
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL mid_pre_count got=%0d exp=5", count); end
        #2;
        Reset = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL mid_async got valid=%0b count=%0d exp 0/0", rd_valid, count); end
        checks++; if (overflow !== 1'b0 || done !== 1'b0 || rd_data !== '0) begin errors++; $display("FAIL mid_flags got ovf=%0b done=%0b data=%0h exp 0/0/0", overflow, done, rd_data); end
        do_reset();
        tick();
        checks++; if (count !== 5'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL mid_after got count=%0d valid=%0b exp 0/0", count, rd_valid); end
    endtask

    initial begin
        Reset = 1'b0; Wr = 1'b0; Halted = 1'b0; rd_req = 1'b0; Addr = '0; Dout = '0;
        model_clear();
        test_reset();
        test_first_write();
        test_overflow();
        test_full_push_pop();
        test_halt();
        test_empty_read();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
